// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Purpose  : Registered fetch PC with IDLE/RUN/TRAP control, stall/redirect
//            handling and a direct-mapped branch target buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0,
    parameter int                         BTB_ENTRIES   = 16,
    parameter bit                         ENABLE_BTB    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     update_valid,
    input  logic [ADDRESS_WIDTH-1:0] update_pc,
    input  logic [ADDRESS_WIDTH-1:0] update_target,
    input  logic                     update_taken,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pcplus4,
    output logic                     pc_valid,
    output logic                     pred_taken,
    output logic                     misaligned
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDRESS_WIDTH - IDX - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] btb_target;
    logic [ADDRESS_WIDTH-1:0] next_pc;
    logic                     run;

    assign run     = (state == RUN);
    assign pcplus4 = pc + ADDRESS_WIDTH'(4);

    always_comb begin
        next_pc = pcplus4;
        if (redirect_valid)  next_pc = redirect_pc;
        else if (stall)      next_pc = pc;
        else if (pred_taken) next_pc = btb_target;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            pc_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= RESET_VECTOR;
                    if (trigger) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!trigger) begin
                        state    <= IDLE;
                        pc       <= RESET_VECTOR;
                        pc_valid <= 1'b0;
                    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                        // pc keeps the last good value for trap diagnosis
                        state      <= TRAP;
                        pc_valid   <= 1'b0;
                        misaligned <= 1'b1;
                    end else begin
                        pc <= next_pc;
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state    <= IDLE;
                    pc       <= RESET_VECTOR;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (ENABLE_BTB) begin : g_btb
            logic [BTB_ENTRIES-1:0]   valid;
            logic [TAG_W-1:0]         tags    [BTB_ENTRIES];
            logic [ADDRESS_WIDTH-1:0] targets [BTB_ENTRIES];
            logic [1:0]               ctrs    [BTB_ENTRIES];

            logic [IDX-1:0]   rd_idx;
            logic [IDX-1:0]   wr_idx;
            logic [TAG_W-1:0] rd_tag;
            logic [TAG_W-1:0] wr_tag;
            logic             rd_hit;
            logic             wr_hit;
            logic             unused_lsbs;

            assign rd_idx      = pc[IDX+1:2];
            assign rd_tag      = pc[ADDRESS_WIDTH-1:IDX+2];
            assign wr_idx      = update_pc[IDX+1:2];
            assign wr_tag      = update_pc[ADDRESS_WIDTH-1:IDX+2];
            assign rd_hit      = valid[rd_idx] && (tags[rd_idx] == rd_tag);
            assign wr_hit      = valid[wr_idx] && (tags[wr_idx] == wr_tag);
            assign pred_taken  = rd_hit && ctrs[rd_idx][1];
            assign btb_target  = targets[rd_idx];
            assign unused_lsbs = ^update_pc[1:0];

            // Lookup reads the array combinationally, so a same-cycle write
            // to the entry being fetched only shows up on the next cycle.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid <= '0;
                end else if (run && update_valid) begin
                    if (wr_hit) begin
                        if (update_taken) begin
                            if (ctrs[wr_idx] != 2'd3) ctrs[wr_idx] <= ctrs[wr_idx] + 2'd1;
                            targets[wr_idx] <= update_target;
                        end else if (ctrs[wr_idx] != 2'd0) begin
                            ctrs[wr_idx] <= ctrs[wr_idx] - 2'd1;
                        end
                    end else if (update_taken) begin
                        valid[wr_idx]   <= 1'b1;
                        tags[wr_idx]    <= wr_tag;
                        targets[wr_idx] <= update_target;
                        ctrs[wr_idx]    <= 2'd2;
                    end
                end
            end
        end else begin : g_no_btb
            logic unused_update;

            assign pred_taken    = 1'b0;
            assign btb_target    = '0;
            assign unused_update = ^{update_valid, update_pc, update_target, update_taken};
        end
    endgenerate

endmodule
`default_nettype wire
